// File: rtl/buzzer_note_bank_pkg.sv
// Shared types and defaults for the buzzer note bank.
package buzzer_note_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } ch_state_e;

    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_DIV_W    = 16;
    localparam int DEF_DUR_W    = 12;
    localparam int DEF_TICK_DIV = 1000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buzzer_tone_channel.sv
// One buzzer channel: IDLE/PLAY FSM with half-period, tick and duration
// counters. Exposes the next tone value so the parent can register the
// muted buzzer output on the same edge as the tone itself.
module buzzer_tone_channel
    import buzzer_note_bank_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] ld_half,
    input  logic [DUR_W-1:0] ld_dur,
    output logic             tone_nxt,
    output logic             busy,
    output logic             done
);

    localparam int TK_W = $clog2(TICK_DIV);

    ch_state_e        state_q,    state_d;
    logic [DIV_W-1:0] half_q,     half_d;
    logic [DIV_W-1:0] half_cnt_q, half_cnt_d;
    logic [TK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q,  dur_cnt_d;
    logic             tone_q,     tone_d;
    logic             done_q,     done_d;

    // Next-state: a load always wins over counting, so a note finishing on
    // the same edge as a new command is silently replaced (no done).
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        half_cnt_d = half_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        tone_d     = tone_q;
        done_d     = 1'b0;

        if (load) begin
            if (ld_dur == '0) begin
                // Stop command: reports done even if the channel was idle.
                state_d    = ST_IDLE;
                half_d     = '0;
                half_cnt_d = '0;
                tick_cnt_d = '0;
                dur_cnt_d  = '0;
                tone_d     = 1'b0;
                done_d     = 1'b1;
            end else begin
                state_d    = ST_PLAY;
                half_d     = ld_half;
                half_cnt_d = (ld_half == '0) ? '0 : ld_half - DIV_W'(1);
                tick_cnt_d = TK_W'(TICK_DIV - 1);
                dur_cnt_d  = ld_dur;
                tone_d     = (ld_half != '0);
            end
        end else if (state_q == ST_PLAY) begin
            // Half-period counter; half=0 is a rest and never toggles.
            if (half_q != '0) begin
                if (half_cnt_q == '0) begin
                    half_cnt_d = half_q - DIV_W'(1);
                    tone_d     = ~tone_q;
                end else begin
                    half_cnt_d = half_cnt_q - DIV_W'(1);
                end
            end
            // Tick prescaler drives the duration countdown.
            if (tick_cnt_q == '0) begin
                if (dur_cnt_q == DUR_W'(1)) begin
                    state_d    = ST_IDLE;
                    half_d     = '0;
                    half_cnt_d = '0;
                    tick_cnt_d = '0;
                    dur_cnt_d  = '0;
                    tone_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    tick_cnt_d = TK_W'(TICK_DIV - 1);
                    dur_cnt_d  = dur_cnt_q - DUR_W'(1);
                end
            end else begin
                tick_cnt_d = tick_cnt_q - TK_W'(1);
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_q     <= '0;
            half_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            half_cnt_q <= half_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
        end
    end

    assign tone_nxt = tone_d;
    assign busy     = (state_q == ST_PLAY);
    assign done     = done_q;

endmodule

// File: rtl/buzzer_note_bank.sv
// N-channel square-wave note generator. Decodes the command channel into a
// per-channel load strobe, and registers the muted buzzer outputs.
module buzzer_note_bank
    import buzzer_note_bank_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cmd_ch,
    input  logic [DIV_W-1:0]              cmd_half,
    input  logic [DUR_W-1:0]              cmd_dur,
    input  logic [NUM_CH-1:0]             mute,
    output logic [NUM_CH-1:0]             buzzer,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             done
);

    logic              cmd_ready_q, cmd_ready_d;
    logic [NUM_CH-1:0] buzzer_q,    buzzer_d;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] tone_nxt;

    // Channel decode; out-of-range channels match nothing and are dropped.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_valid && cmd_ready_q && (32'(cmd_ch) == 32'(i))) begin
                load[i] = 1'b1;
            end
        end
    end

    // Ready comes up one edge after reset release and then stays high;
    // mute is applied to the tone value that is being registered this edge.
    always_comb begin
        cmd_ready_d = 1'b1;
        buzzer_d    = tone_nxt & ~mute;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            buzzer_q    <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            buzzer_q    <= buzzer_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        buzzer_tone_channel #(
            .DIV_W    (DIV_W),
            .DUR_W    (DUR_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .ld_half  (cmd_half),
            .ld_dur   (cmd_dur),
            .tone_nxt (tone_nxt[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    assign cmd_ready = cmd_ready_q;
    assign buzzer    = buzzer_q;

endmodule
